// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: two-source AXI-Stream packet arbiter with round-robin, packet-locked grants,
// a registered output stage, overlong-packet truncation and packet/error status.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic                    err_overlong
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);
    state_t                  state_q, state_d;
    logic                    ptr_q, err_q, tvalid_q, tlast_q;
    logic [1:0]              grant_q;
    logic [15:0]             beat_q;
    logic [CNT_WIDTH-1:0]    pkt_q;
    logic [DATA_WIDTH-1:0]   tdata_q, in_data;
    logic [DATA_WIDTH/8-1:0] tstrb_q, in_strb;
    logic                    out_free, acc, in_last, at_max, pkt_end;

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free        = !tvalid_q || m00_axis_tready;
    assign s00_axis_tready = state_q == GNT0 && out_free;
    assign s01_axis_tready = state_q == GNT1 && out_free;
    assign acc     = (s00_axis_tready && s00_axis_tvalid) || (s01_axis_tready && s01_axis_tvalid);
    assign in_data = state_q == GNT1 ? s01_axis_tdata : s00_axis_tdata;
    assign in_strb = state_q == GNT1 ? s01_axis_tstrb : s00_axis_tstrb;
    assign in_last = state_q == GNT1 ? s01_axis_tlast : s00_axis_tlast;
    assign at_max  = beat_q == LAST_BEAT;
    assign pkt_end = acc && (in_last || at_max);

    always_comb begin
        state_d = state_q == IDLE ? (s00_axis_tvalid && !(s01_axis_tvalid && ptr_q) ? GNT0 :
                                     s01_axis_tvalid ? GNT1 : IDLE) :
                  pkt_end ? IDLE : state_q;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            ptr_q    <= 1'b0;
            beat_q   <= '0;
            pkt_q    <= '0;
            err_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= {state_d == GNT1, state_d == GNT0};
            tvalid_q <= acc || (tvalid_q && !m00_axis_tready);
            beat_q   <= pkt_end ? '0 : beat_q + 16'(acc);
            if (acc) begin
                tdata_q <= in_data;
                tstrb_q <= in_strb;
                tlast_q <= in_last || at_max;
            end
            if (pkt_end) begin
                ptr_q <= state_q == GNT0;
                pkt_q <= pkt_q + CNT_WIDTH'(1);
            end
            // A packet end without tlast can only be the forced truncation.
            if (pkt_end && !in_last) err_q <= 1'b1;
        end
    end

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = tstrb_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign grant           = grant_q;
    assign pkt_count       = pkt_q;
    assign err_overlong    = err_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed bench for the AXI-Stream round-robin arbiter; a second
// instance with a 2-bit packet counter shares the stimulus to exercise counter wrap.
module tb_axis_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s0_data, s1_data, m_data, w_m_data;
    logic [3:0]  s0_strb, s1_strb, m_strb, w_m_strb;
    logic        s0_valid, s1_valid, s0_last, s1_last, s0_ready, s1_ready;
    logic        m_valid, m_last, m_ready, err, w_s0_ready, w_s1_ready, w_m_valid, w_m_last, w_err;
    logic [1:0]  grant, w_grant, w_pkt;
    logic [15:0] pkt;
    int          n_chk = 0, n_err = 0;
    int          k0 = 0, k1 = 0, tot0 = 0, tot1 = 0, pl0 = 1, pl1 = 1;
    logic [31:0] base0 = 0, base1 = 0, vhist = 0, rhist = 0;
    logic [36:0] outq[$], expq[$];

    always #5 clk = ~clk;

    axis_rr_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4), .CNT_WIDTH(16)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s00_axis_tdata(s0_data), .s00_axis_tstrb(s0_strb), .s00_axis_tvalid(s0_valid),
        .s00_axis_tlast(s0_last), .s00_axis_tready(s0_ready),
        .s01_axis_tdata(s1_data), .s01_axis_tstrb(s1_strb), .s01_axis_tvalid(s1_valid),
        .s01_axis_tlast(s1_last), .s01_axis_tready(s1_ready),
        .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb), .m00_axis_tvalid(m_valid),
        .m00_axis_tlast(m_last), .m00_axis_tready(m_ready),
        .grant(grant), .pkt_count(pkt), .err_overlong(err)
    );

    axis_rr_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4), .CNT_WIDTH(2)) dut_w (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s00_axis_tdata(s0_data), .s00_axis_tstrb(s0_strb), .s00_axis_tvalid(s0_valid),
        .s00_axis_tlast(s0_last), .s00_axis_tready(w_s0_ready),
        .s01_axis_tdata(s1_data), .s01_axis_tstrb(s1_strb), .s01_axis_tvalid(s1_valid),
        .s01_axis_tlast(s1_last), .s01_axis_tready(w_s1_ready),
        .m00_axis_tdata(w_m_data), .m00_axis_tstrb(w_m_strb), .m00_axis_tvalid(w_m_valid),
        .m00_axis_tlast(w_m_last), .m00_axis_tready(m_ready),
        .grant(w_grant), .pkt_count(w_pkt), .err_overlong(w_err)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        s0_valid = k0 < tot0;
        s0_data  = base0 + 32'(k0);
        s0_last  = (k0 % pl0) == pl0 - 1;
        s0_strb  = 4'hF;
        s1_valid = k1 < tot1;
        s1_data  = base1 + 32'(k1);
        s1_last  = (k1 % pl1) == pl1 - 1;
        s1_strb  = 4'h3;
    endtask

    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        vhist = {vhist[30:0], m_valid};
        rhist = {rhist[30:0], s1_ready};
        if (m_valid && m_ready) outq.push_back({m_last, m_strb, m_data});
        @(posedge clk);
        #1;
        k0 += int'(a0);
        k1 += int'(a1);
    endtask

    task automatic run(int n, logic [31:0] rdy);
        for (int i = 0; i < n; i++) begin
            drive();
            m_ready = rdy[i];
            tick();
        end
    endtask

    task automatic ex(logic last, logic [3:0] strb, logic [31:0] d);
        expq.push_back({last, strb, d});
    endtask

    task automatic cmpq(string tag);
        check({tag, "_len"}, 64'(outq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            check($sformatf("%s[%0d]", tag, i), i < outq.size() ? outq[i] : '0, expq[i]);
        expq.delete();
    endtask

    task automatic rst();
        rst_n = 1'b0;
        tot0 = 0; tot1 = 0; k0 = 0; k1 = 0;
        drive();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        outq.delete();
        vhist = 0;
        rhist = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int wexp[5] = '{1, 2, 3, 0, 1};
        rst();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_strb", m_strb, 0);
        check("rst_m_last", m_last, 0);
        check("rst_grant", grant, 0);
        check("rst_pkt", pkt, 0);
        check("rst_err", err, 0);
        check("rst_s_ready", {s0_ready, s1_ready}, 0);
        check("rst_w_pkt", w_pkt, 0);

        // single source, 4 beats, tlast exactly on the MAX_BEATS beat
        tot0 = 4; pl0 = 4; base0 = 32'hA0;
        run(3, '1);
        check("single_grant_busy", grant, 2'b01);
        run(4, '1);
        check("single_grant_idle", grant, 2'b00);
        check("single_pkt", pkt, 1);
        check("single_err", err, 0);
        check("single_valid_hist", vhist[6:0], 7'b0011110);
        ex(0, 4'hF, 32'hA0); ex(0, 4'hF, 32'hA1); ex(0, 4'hF, 32'hA2); ex(1, 4'hF, 32'hA3);
        cmpq("single_beat");

        // contention: both sources stream 3-beat packets
        rst();
        tot0 = 6; pl0 = 3; base0 = 32'h100;
        tot1 = 6; pl1 = 3; base1 = 32'h200;
        run(18, '1);
        check("cont_valid_hist", vhist[17:0], 18'h0EEEE);
        check("cont_pkt", pkt, 4);
        check("cont_grant", grant, 2'b00);
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 3; b++)
                ex(b == 2, p[0] ? 4'h3 : 4'hF, (p[0] ? 32'h200 : 32'h100) + 32'(3 * (p / 2) + b));
        cmpq("cont_beat");

        // backpressure during an s01 packet
        rst();
        tot1 = 4; pl1 = 4; base1 = 32'h300;
        run(4, 32'h3);
        check("bp_hold_data", m_data, 32'h300);
        check("bp_hold_valid", m_valid, 1);
        check("bp_s1_ready_low", s1_ready, 0);
        run(5, '1);
        check("bp_ready_hist", rhist[8:0], 9'b010011100);
        check("bp_pkt", pkt, 1);
        ex(0, 4'h3, 32'h300); ex(0, 4'h3, 32'h301); ex(0, 4'h3, 32'h302); ex(1, 4'h3, 32'h303);
        cmpq("bp_beat");

        // overlong packet truncated at MAX_BEATS=4
        rst();
        check("ovl_err_before", err, 0);
        tot0 = 6; pl0 = 6; base0 = 32'h400;
        run(10, '1);
        check("ovl_err", err, 1);
        check("ovl_pkt", pkt, 2);
        ex(0, 4'hF, 32'h400); ex(0, 4'hF, 32'h401); ex(0, 4'hF, 32'h402); ex(1, 4'hF, 32'h403);
        ex(0, 4'hF, 32'h404); ex(1, 4'hF, 32'h405);
        cmpq("ovl_beat");

        // asynchronous reset in the middle of a 5-beat packet
        tot0 = 5; pl0 = 5; base0 = 32'h500; k0 = 0;
        run(3, '1);
        check("mid_valid_before", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_pkt", pkt, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_s0_ready", s0_ready, 0);
        tot0 = 0; k0 = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        outq.delete();
        tot1 = 1; pl1 = 1; base1 = 32'h600; k1 = 0;
        run(1, '1);
        check("mid_new_grant", grant, 2'b10);
        run(3, '1);
        check("mid_new_pkt", pkt, 1);
        ex(1, 4'h3, 32'h600);
        cmpq("mid_new_beat");

        // 2-bit packet counter wrap on single-beat packets
        rst();
        tot0 = 5; pl0 = 1; base0 = 32'h700;
        for (int j = 0; j < 5; j++) begin
            run(2, '1);
            check($sformatf("wrap_pkt[%0d]", j), w_pkt, wexp[j]);
        end
        check("wrap_wide_pkt", pkt, 5);
        check("wrap_err", w_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
